// File: rtl/alu_muldiv_ctrl.sv
// ALU control decoder with an iterative multiply/divide sequencer.
// Single-cycle ops decode combinationally; M-extension ops run one bit per cycle.
module alu_muldiv_ctrl #(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            valid_in,
  input  logic [1:0]      ALUOp,
  input  logic [2:0]      func3,
  input  logic [6:0]      func7,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [3:0]      ALUControl,
  output logic            illegal,
  output logic            ready,
  output logic            busy,
  output logic            md_valid,
  output logic [XLEN-1:0] md_result
);

  localparam int            CW   = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLTU = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001,
    ALU_NOP  = 4'b1111
  } alu_ctl_t;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  alu_ctl_t ctl;
  logic     m_op;

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case statements can infer a latch.
  always_comb begin
    ctl     = ALU_NOP;
    illegal = 1'b0;
    m_op    = 1'b0;
    unique case (ALUOp)
      2'b00: ctl = ALU_ADD;
      2'b01: ctl = ALU_SUB;
      2'b10: begin
        unique case (func7)
          7'b0000000: begin
            unique case (func3)
              3'b000: ctl = ALU_ADD;
              3'b001: ctl = ALU_SLL;
              3'b010: ctl = ALU_SLT;
              3'b011: ctl = ALU_SLTU;
              3'b100: ctl = ALU_XOR;
              3'b101: ctl = ALU_SRL;
              3'b110: ctl = ALU_OR;
              default: ctl = ALU_AND;
            endcase
          end
          7'b0100000: begin
            if (func3 == 3'b000)      ctl = ALU_SUB;
            else if (func3 == 3'b101) ctl = ALU_SRA;
            else                      illegal = 1'b1;
          end
          7'b0000001: begin
            if (ENABLE_M) m_op    = 1'b1;
            else          illegal = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      default: begin
        unique case (func3)
          3'b000: ctl = ALU_ADD;
          3'b010: ctl = ALU_SLT;
          3'b011: ctl = ALU_SLTU;
          3'b100: ctl = ALU_XOR;
          3'b110: ctl = ALU_OR;
          3'b111: ctl = ALU_AND;
          3'b001: begin
            if (func7 == 7'b0000000) ctl = ALU_SLL;
            else                     illegal = 1'b1;
          end
          default: begin
            if (func7 == 7'b0000000)      ctl = ALU_SRL;
            else if (func7 == 7'b0100000) ctl = ALU_SRA;
            else                          illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

  assign ALUControl = ctl;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;     // mul: {product hi, multiplier/product lo}; div: {remainder, quotient}
  logic [XLEN-1:0]   opnd;    // multiplicand or divisor magnitude
  logic [2:0]        op_f3;
  logic              neg_lo;
  logic              neg_hi;
  logic [XLEN-1:0]   held;

  // Operand signedness: MUL/MULH both signed, MULHSU only a, DIV/REM both.
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] mag_a, mag_b;

  always_comb begin
    if (func3[2]) begin
      a_signed = ~func3[0];
      b_signed = ~func3[0];
    end else begin
      a_signed = (func3[1:0] != 2'b11);
      b_signed = ~func3[1];
    end
    a_neg = a_signed & a[XLEN-1];
    b_neg = b_signed & b[XLEN-1];
    mag_a = a_neg ? -a : a;
    mag_b = b_neg ? -b : b;
  end

  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic              div_geq;
  logic [2*XLEN-1:0] acc_step;

  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    div_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff = div_sh - {1'b0, opnd};
    div_geq  = (div_sh >= {1'b0, opnd});
    if (state == S_DIV)
      acc_step = {(div_geq ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0]), acc[XLEN-2:0], div_geq};
    else
      acc_step = {mul_sum, acc[XLEN-1:1]};
  end

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, final_res;

  always_comb begin
    prod_fix = neg_lo ? -acc : acc;
    quo_fix  = neg_lo ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_fix  = neg_hi ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    unique case (op_f3)
      3'b000:                 final_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_res = quo_fix;
      default:                final_res = rem_fix;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      op_f3  <= '0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      held   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (valid_in && m_op && !flush) begin
            op_f3  <= func3;
            cnt    <= '0;
            neg_lo <= a_neg ^ b_neg;
            neg_hi <= a_neg;
            if (!func3[2]) begin
              acc   <= {{XLEN{1'b0}}, mag_b};
              opnd  <= mag_a;
              state <= S_MUL;
            end else if (b == '0) begin
              // Divide by zero: preload quotient all ones and remainder a, skip iterations.
              acc    <= {a, {XLEN{1'b1}}};
              neg_lo <= 1'b0;
              neg_hi <= 1'b0;
              state  <= S_DONE;
            end else begin
              acc   <= {{XLEN{1'b0}}, mag_a};
              opnd  <= mag_b;
              state <= S_DIV;
            end
          end
        end
        S_MUL, S_DIV: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            acc <= acc_step;
            cnt <= cnt + CW'(1);
            if (cnt == LAST) state <= S_DONE;
          end
        end
        default: begin
          if (!flush) held <= final_res;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // A flush in DONE suppresses the pulse and leaves the visible result untouched.
  assign ready     = (state == S_IDLE);
  assign busy      = (state == S_MUL) || (state == S_DIV);
  assign md_valid  = (state == S_DONE) && !flush;
  assign md_result = md_valid ? final_res : held;

endmodule

// File: doc/alu_muldiv_ctrl.md
ALU_MULDIV_CTRL -- requirements
Module: alu_muldiv_ctrl

Interface
REQ-001 Parameter XLEN, default 32, operand/result width (≥8, even).
REQ-002 Parameter ENABLE_M, default 1; 0 = M-extension ops decode as illegal, FSM never leaves IDLE.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 flush  input  1  synchronous abort of any in-flight mul/div.
REQ-006 valid_in  input  1  operation presented this cycle.
REQ-007 ALUOp  input  2  00 store, 01 branch, 10 R-type, 11 I-type.
REQ-008 func3  input  3  instruction funct3.
REQ-009 func7  input  7  instruction funct7 (full field).
REQ-010 a, b  input  XLEN  operands (a = rs1, b = rs2/imm).
REQ-011 ALUControl  output  4  single-cycle ALU select (combinational).
REQ-012 illegal  output  1  combinational; undefined encoding.
REQ-013 ready  output  1  high only in IDLE.
REQ-014 busy  output  1  high in MUL or DIV state.
REQ-015 md_valid  output  1  one-cycle pulse, mul/div result valid.
REQ-016 md_result  output  XLEN  mul/div result, held until next accepted mul/div.

Function
REQ-017 ALUControl encoding: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001, NOP 1111.
REQ-018 ALUOp 00 -> ADD; 01 -> SUB; never illegal.
REQ-019 R-type, func7 0000000: func3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
REQ-020 R-type, func7 0100000: func3 000 SUB, 101 SRA; all other func3 illegal.
REQ-021 R-type, func7 0000001 with ENABLE_M=1: mul/div op (func3 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU); ALUControl = NOP.
REQ-022 I-type: func3 000 ADD, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND; 001 SLL when func7=0000000; 101 SRL when func7=0000000, SRA when func7=0100000; other func7 on 001/101 illegal.
REQ-023 Any illegal encoding: ALUControl = NOP, illegal = 1; no state change.
REQ-024 FSM states IDLE, MUL, DIV, DONE.
REQ-025 IDLE -> MUL/DIV when valid_in & ready & legal M op; operands, func3 latched that edge.
REQ-026 MUL: shift-add, one bit per cycle, XLEN cycles, 2*XLEN-bit product on operand magnitudes; sign fix-up per op (MULHSU: only a signed).
REQ-027 DIV: restoring, one bit per cycle, XLEN cycles on magnitudes; quotient sign = sign(a) XOR sign(b); remainder sign = sign(a) (signed ops).
REQ-028 Result select: MUL low XLEN bits; MULH/MULHSU/MULHU high XLEN bits; DIV/DIVU quotient; REM/REMU remainder.
REQ-029 MUL/DIV -> DONE after XLEN-th iteration; DONE -> IDLE next cycle with md_valid = 1 in DONE; latency accept-edge to md_valid = XLEN+1 cycles.
REQ-030 Divide by zero: detected at accept, direct to DONE (latency 1); quotient all ones, remainder = a.
REQ-031 Signed overflow (a = -2^(XLEN-1), b = -1, DIV/REM): quotient = a, remainder 0, normal latency.
REQ-032 valid_in while not ready: ignored, no latch, no error.
REQ-033 Single-cycle ops accepted in any state; only ALUControl/illegal respond, FSM unaffected.
REQ-034 flush in MUL/DIV/DONE: next state IDLE, no md_valid, md_result unchanged; flush in IDLE with valid_in: operation not accepted.

Reset
REQ-035 rst asserted: state IDLE, md_result 0, md_valid 0, busy 0, ready 1, iteration counter 0, immediately (no clock required).
REQ-036 rst mid-operation: in-flight op discarded; no md_valid after release.
REQ-037 First accept possible on first rising edge after rst deasserts.

Verification
REQ-038 ALUOp=10, func3=000, func7=0100000 -> ALUControl 0001, illegal 0; func7=0000010 -> ALUControl 1111, illegal 1.
REQ-039 XLEN=32, MULH a=0xFFFFFFFF, b=0x00000002 -> md_result 0xFFFFFFFF, md_valid exactly 33 cycles after accept.
REQ-040 DIV a=-7, b=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU a=7, b=0 -> 0xFFFFFFFF one cycle after accept.
REQ-041 DIV a=0x80000000, b=0xFFFFFFFF -> quotient 0x80000000; REM -> 0.
REQ-042 rst pulsed at iteration 10 of MUL -> busy 0 asynchronously, no md_valid; new MUL 3*5 afterwards -> 15.
REQ-043 valid_in with DIVU while busy -> ignored, original result correct; flush mid-DIV -> ready next cycle, md_result unchanged.
